// File: rtl/usi_uart_master_bridge.sv
// UART-to-USI bus master: decodes 8N1 command frames into single USI write/read cycles
// and returns ACK/NAK plus read data over UART TX.
module usi_uart_master_bridge #(
  parameter int pClkDiv          = 868,
  parameter int pBusAdrsBit      = 16,
  parameter int pBusSlaveConnect = 9,
  parameter int pRdTimeout       = 255
) (
  input  logic                        iSysClk,
  input  logic                        iSysRst,
  input  logic                        iUartRx,
  output logic                        oUartTx,
  output logic [31:0]                 oMUsiWd,
  output logic [pBusAdrsBit-1:0]      oMUsiAdrs,
  output logic                        oMUsiWEd,
  output logic                        oMUsiREd,
  input  logic [31:0]                 iMUsiRd,
  input  logic [pBusSlaveConnect-1:0] iMUsiVd,
  output logic                        oBusy
);
  localparam int CW = $clog2(pClkDiv);
  localparam int TW = $clog2(pRdTimeout + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(pClkDiv - 1);
  localparam logic [CW-1:0] HALF_END = CW'(pClkDiv / 2 - 1);
  localparam logic [TW-1:0] TMO_END  = TW'(pRdTimeout - 1);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

  localparam logic [3:0] P_IDLE = 4'd0, P_ADRH = 4'd1, P_ADRL = 4'd2, P_D3 = 4'd3,
                         P_D2 = 4'd4, P_D1 = 4'd5, P_D0 = 4'd6, P_BUSW = 4'd7,
                         P_BUSR = 4'd8, P_WAITV = 4'd9, P_RESP = 4'd10;

  localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52, ACK = 8'h06, NAK = 8'h15;

  // RX synchroniser; rx_s3_q is the previous synchronised sample for edge detection
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid, rx_ferr;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    case (rx_st_q)
      RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_st_d  = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: if (rx_cnt_q == BIT_END) rx_st_d = RX_IDLE;
               else rx_cnt_d = rx_cnt_q + 1'b1;
    endcase
  end

  assign rx_valid = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_END) &&  rx_s2_q;
  assign rx_ferr  = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_END) && !rx_s2_q;

  // Parser / bus side
  logic [3:0]             ps_q, ps_d;
  logic                   is_wr_q, is_wr_d;
  logic [7:0]             adr_hi_q, adr_hi_d;
  logic [23:0]            wd_sh_q, wd_sh_d;
  logic [pBusAdrsBit-1:0] adrs_q, adrs_d;
  logic [31:0]            wd_q, wd_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [39:0]            resp_q, resp_d;
  logic [2:0]             resp_n_q, resp_n_d;
  logic                   busy_q, busy_d;

  // TX: 10-bit frame shifter, idles all-ones so bit 0 is the line
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_act_q, tx_act_d;
  logic          tx_done, tx_free, tx_load;

  assign tx_done = tx_act_q && (tx_cnt_q == BIT_END) && (tx_bit_q == 4'd9);
  assign tx_free = !tx_act_q || tx_done;
  assign tx_load = (ps_q == P_RESP) && (resp_n_q != 3'd0) && tx_free;

  always_comb begin
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_act_d = tx_act_q;
    if (tx_load) begin
      tx_sh_d  = {1'b1, resp_q[39:32], 1'b0};
      tx_cnt_d = '0;
      tx_bit_d = '0;
      tx_act_d = 1'b1;
    end else if (tx_act_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b1, tx_sh_q[9:1]};
        if (tx_bit_q == 4'd9) tx_act_d = 1'b0;
        else tx_bit_d = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_comb begin
    ps_d     = ps_q;
    is_wr_d  = is_wr_q;
    adr_hi_d = adr_hi_q;
    wd_sh_d  = wd_sh_q;
    adrs_d   = adrs_q;
    wd_d     = wd_q;
    tmo_d    = tmo_q;
    resp_d   = resp_q;
    resp_n_d = resp_n_q;
    busy_d   = busy_q;
    case (ps_q)
      P_IDLE: if (rx_valid) begin
        busy_d = 1'b1;
        if (rx_sh_q == OP_WR || rx_sh_q == OP_RD) begin
          is_wr_d = (rx_sh_q == OP_WR);
          ps_d    = P_ADRH;
        end else begin
          resp_d   = {NAK, 32'h0};
          resp_n_d = 3'd1;
          ps_d     = P_RESP;
        end
      end
      P_ADRH, P_ADRL, P_D3, P_D2, P_D1, P_D0: begin
        if (rx_ferr) begin
          ps_d   = P_IDLE;
          busy_d = 1'b0;
        end else if (rx_valid) begin
          case (ps_q)
            P_ADRH: begin adr_hi_d = rx_sh_q; ps_d = P_ADRL; end
            P_ADRL: begin
              adrs_d = pBusAdrsBit'({adr_hi_q, rx_sh_q});
              ps_d   = is_wr_q ? P_D3 : P_BUSR;
            end
            P_D0: begin wd_d = {wd_sh_q, rx_sh_q}; ps_d = P_BUSW; end
            default: begin wd_sh_d = {wd_sh_q[15:0], rx_sh_q}; ps_d = ps_q + 1'b1; end
          endcase
        end
      end
      P_BUSW: begin
        resp_d   = {ACK, 32'h0};
        resp_n_d = 3'd1;
        ps_d     = P_RESP;
      end
      P_BUSR: begin
        tmo_d = '0;
        ps_d  = P_WAITV;
      end
      P_WAITV: if (|iMUsiVd) begin
        resp_d   = {ACK, iMUsiRd};
        resp_n_d = 3'd5;
        ps_d     = P_RESP;
      end else if (tmo_q == TMO_END) begin
        resp_d   = {NAK, 32'h0};
        resp_n_d = 3'd1;
        ps_d     = P_RESP;
      end else tmo_d = tmo_q + 1'b1;
      default: if (tx_load) begin
        resp_d   = {resp_q[31:0], 8'h0};
        resp_n_d = resp_n_q - 1'b1;
      end else if (resp_n_q == 3'd0 && tx_free) begin
        ps_d   = P_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      ps_q     <= P_IDLE;
      is_wr_q  <= 1'b0;
      adr_hi_q <= '0;
      wd_sh_q  <= '0;
      adrs_q   <= '0;
      wd_q     <= '0;
      tmo_q    <= '0;
      resp_q   <= '0;
      resp_n_q <= '0;
      busy_q   <= 1'b0;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_act_q <= 1'b0;
    end else begin
      rx_s1_q  <= iUartRx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      ps_q     <= ps_d;
      is_wr_q  <= is_wr_d;
      adr_hi_q <= adr_hi_d;
      wd_sh_q  <= wd_sh_d;
      adrs_q   <= adrs_d;
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
      resp_q   <= resp_d;
      resp_n_q <= resp_n_d;
      busy_q   <= busy_d;
      tx_sh_q  <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_act_q <= tx_act_d;
    end
  end

  assign oUartTx   = tx_sh_q[0];
  assign oMUsiWd   = wd_q;
  assign oMUsiAdrs = adrs_q;
  assign oMUsiWEd  = (ps_q == P_BUSW);
  assign oMUsiREd  = (ps_q == P_BUSR);
  assign oBusy     = busy_q;
endmodule

// File: tb/tb_usi_uart_master_bridge.sv
// Directed bench for usi_uart_master_bridge: drives UART frames, models a USI slave,
// decodes the UART response stream and checks bus activity against hand-computed values.
module tb_usi_uart_master_bridge;
  localparam int P = 16;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        rx;
  logic        tx;
  logic [31:0] wd;
  logic [15:0] adrs;
  logic        wed, red, busy;
  logic [31:0] rd;
  logic [8:0]  vd;
  logic        slave_en;

  always #5 gclk = ~gclk;

  usi_uart_master_bridge #(
    .pClkDiv(P), .pBusAdrsBit(16), .pBusSlaveConnect(9), .pRdTimeout(255)
  ) dut (
    .iSysClk(gclk), .iSysRst(grst_n), .iUartRx(rx), .oUartTx(tx),
    .oMUsiWd(wd), .oMUsiAdrs(adrs), .oMUsiWEd(wed), .oMUsiREd(red),
    .iMUsiRd(rd), .iMUsiVd(vd), .oBusy(busy)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int wed_n = 0, red_n = 0, busy_n = 0, red_cyc = 0;
  logic [15:0] wr_adrs, rd_adrs;
  logic [31:0] wr_wd;
  logic [7:0]  rxq[$];
  int          stq[$];
  int          last_start;
  logic [7:0]  fr[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  always @(posedge gclk) cyc++;

  always @(negedge gclk) begin
    if (wed)  begin wed_n++; wr_adrs = adrs; wr_wd = wd; end
    if (red)  begin red_n++; rd_adrs = adrs; red_cyc = cyc; end
    if (busy) busy_n++;
  end

  // USI slave: answers a read 5 cycles after the request when enabled
  initial begin
    vd = '0;
    rd = '0;
    forever begin
      @(negedge gclk);
      if (red && slave_en) begin
        repeat (5) @(negedge gclk);
        vd = 9'h002;
        rd = 32'hCAFEBABE;
        @(negedge gclk);
        vd = '0;
        rd = '0;
      end
    end
  end

  // UART receiver for the DUT's TX line
  initial begin
    forever begin
      logic [7:0] b;
      int st;
      @(negedge tx);
      st = cyc;
      repeat (P/2) @(posedge gclk);
      #1;
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(posedge gclk);
          #1;
          b[i] = tx;
        end
        repeat (P) @(posedge gclk);
        #1;
        if (tx !== 1'b1) b = 8'hxx;
        rxq.push_back(b);
        stq.push_back(st);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (P) @(negedge gclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (P) @(negedge gclk);
    end
    rx = stop;
    repeat (P) @(negedge gclk);
    rx = 1'b1;
    repeat (stop ? 2 : P) @(negedge gclk);
  endtask

  task automatic send_fr();
    foreach (fr[i]) send_byte(fr[i], 1'b1);
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    int t;
    b = 8'hxx;
    t = 0;
    while (rxq.size() == 0 && t < 12*P*10 + 600) begin
      @(posedge gclk);
      t++;
    end
    if (rxq.size() != 0) begin
      b = rxq.pop_front();
      last_start = stq.pop_front();
    end
    chk(tag, {24'h0, b}, {24'h0, exp});
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200*P) begin
      @(negedge gclk);
      t++;
    end
    repeat (2*P) @(negedge gclk);
  endtask

  initial begin
    int w0, r0, b0;
    grst_n   = 1'b0;
    rx       = 1'b1;
    slave_en = 1'b0;
    repeat (5) @(negedge gclk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_wd", wd, 32'h0);
    chk("rst_adrs", {16'h0, adrs}, 32'h0);
    chk("rst_wed", {31'h0, wed}, 32'h0);
    chk("rst_red", {31'h0, red}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    grst_n = 1'b1;
    repeat (5) @(negedge gclk);

    // write 0x12345678 to 0x0003
    w0 = wed_n; r0 = red_n;
    fr = '{8'h57, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
    send_fr();
    chk("wr_busy", {31'h0, busy}, 32'h1);
    get_byte("wr_ack", 8'h06);
    chk("wr_wed_n", wed_n - w0, 1);
    chk("wr_adrs", {16'h0, wr_adrs}, 32'h0003);
    chk("wr_wd", wr_wd, 32'h12345678);
    chk("wr_red_n", red_n - r0, 0);
    wait_idle();
    chk("wr_busy_end", {31'h0, busy}, 32'h0);
    chk("wr_hold_wd", wd, 32'h12345678);

    // read 0x0100, slave answers after 5 cycles
    slave_en = 1'b1;
    r0 = red_n;
    fr = '{8'h52, 8'h01, 8'h00};
    send_fr();
    get_byte("rd_ack", 8'h06);
    get_byte("rd_b3", 8'hCA);
    get_byte("rd_b2", 8'hFE);
    get_byte("rd_b1", 8'hBA);
    get_byte("rd_b0", 8'hBE);
    chk("rd_red_n", red_n - r0, 1);
    chk("rd_adrs", {16'h0, rd_adrs}, 32'h0100);
    wait_idle();
    chk("rd_busy_end", {31'h0, busy}, 32'h0);
    slave_en = 1'b0;

    // read timeout -> single NAK roughly pRdTimeout cycles after the request
    w0 = wed_n;
    fr = '{8'h52, 8'h00, 8'h10};
    send_fr();
    get_byte("tmo_nak", 8'h15);
    chk("tmo_delay", {31'h0, (last_start - red_cyc >= 255) && (last_start - red_cyc <= 262)}, 32'h1);
    chk("tmo_wed_n", wed_n - w0, 0);
    wait_idle();
    chk("tmo_extra", rxq.size(), 0);

    // bad opcode, framing error, then a good write
    send_byte(8'h41, 1'b1);
    get_byte("bad_nak", 8'h15);
    wait_idle();
    b0 = busy_n;
    send_byte(8'hFF, 1'b0);
    repeat (4*P) @(negedge gclk);
    chk("ferr_busy", busy_n - b0, 0);
    chk("ferr_resp", rxq.size(), 0);
    w0 = wed_n;
    fr = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_fr();
    get_byte("ferr_wr_ack", 8'h06);
    chk("ferr_wr_n", wed_n - w0, 1);
    chk("ferr_wr_adrs", {16'h0, wr_adrs}, 32'h0001);
    chk("ferr_wr_wd", wr_wd, 32'h000000FF);
    wait_idle();

    // reset in the middle of D2, then a normal read
    w0 = wed_n;
    fr = '{8'h57, 8'h00, 8'h02, 8'h11};
    send_fr();
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (4*P) @(negedge gclk);
        grst_n = 1'b0;
      end
    join
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    grst_n = 1'b1;
    repeat (3*P) @(negedge gclk);
    slave_en = 1'b1;
    fr = '{8'h52, 8'h00, 8'h02};
    send_fr();
    get_byte("rst_rd_ack", 8'h06);
    get_byte("rst_rd_b3", 8'hCA);
    get_byte("rst_rd_b2", 8'hFE);
    get_byte("rst_rd_b1", 8'hBA);
    get_byte("rst_rd_b0", 8'hBE);
    chk("rst_rd_adrs", {16'h0, rd_adrs}, 32'h0002);
    wait_idle();
    chk("rst_wed_n", wed_n - w0, 0);
    slave_en = 1'b0;

    // one-cycle glitch in idle
    b0 = busy_n;
    rx = 1'b0;
    @(negedge gclk);
    rx = 1'b1;
    repeat (12*P) @(negedge gclk);
    chk("glitch_busy", busy_n - b0, 0);
    chk("glitch_resp", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
